// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC transaction sequencer: register map defaults,
// FSM encoding and write-group identifiers.
package rtc_pkg;

   localparam logic [7:0] DEF_A_SEG   = 8'h21;
   localparam logic [7:0] DEF_A_CRONO = 8'h41;
   localparam logic [7:0] OFF_FECHA   = 8'd3;
   localparam logic [3:0] N_SEG_REGS  = 4'd6;
   localparam logic [3:0] ULT_IDX     = 4'd8;
   localparam logic [1:0] ULT_PASO    = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_GAP   = 2'd3
   } estado_t;

   typedef enum logic [1:0] {
      G_HORA  = 2'd0,
      G_FECHA = 2'd1,
      G_CRONO = 2'd2
   } grupo_t;

   // Burst order is low byte first: ss,mm,hh / dd,mm,aa.
   function automatic logic [7:0] byte_sel(input logic [23:0] w, input logic [1:0] paso);
      case (paso)
         2'd0:    return w[7:0];
         2'd1:    return w[15:8];
         default: return w[23:16];
      endcase
   endfunction

endpackage

// File: rtl/rtc_secuenciador_if.sv
// Handshake between the sequencer and the Protocolo_rtc bus engine.
interface rtc_secuenciador_if;

   logic       inicio;
   logic [7:0] address;
   logic [7:0] DATA_WRITE;
   logic       IndicadorMaquina;
   logic       busy;
   logic       done;

   modport master (
      output inicio, address, DATA_WRITE, IndicadorMaquina, busy,
      input  done
   );

   modport slave (
      input  inicio, address, DATA_WRITE, IndicadorMaquina, busy,
      output done
   );

endinterface

// File: rtl/rtc_temporizador.sv
// Shared down-counter for the inter-transaction gap and the done timeout.
module rtc_temporizador #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/rtc_secuenciador.sv
// Transaction sequencer feeding Protocolo_rtc: continuous read sweep of time,
// date and timer registers, with committed write bursts inserted between reads.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | pick next transaction (active burst > pending write > read)
// S_ISSUE | inicio pulse, transaction fields latched, busy raised
// S_WAIT  | fields held, wait for done or timeout
// S_GAP   | quiet interval before the next decision
module rtc_secuenciador
   import rtc_pkg::*;
#(
   parameter int         GAP_CYC = 16,
   parameter int         TIMEOUT = 512,
   parameter logic [7:0] A_SEG   = DEF_A_SEG,
   parameter logic [7:0] A_CRONO = DEF_A_CRONO
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       camb_hora,
   input  logic                       camb_fecha,
   input  logic                       camb_crono,
   input  logic [23:0]                wr_hora,
   input  logic [23:0]                wr_fecha,
   input  logic [23:0]                wr_crono,
   rtc_secuenciador_if.master         bus,
   output logic                       barrido_fin,
   output logic                       error
);

   localparam int TMAX = (TIMEOUT > GAP_CYC) ? TIMEOUT : GAP_CYC;
   localparam int TW   = $clog2(TMAX + 1);
   localparam logic [TW-1:0] LD_WAIT = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] LD_GAP  = TW'(GAP_CYC - 1);

   estado_t     estado;
   logic [3:0]  rd_idx;
   logic [2:0]  pend;
   logic [23:0] snap_hora, snap_fecha, snap_crono;
   logic        burst_act;
   grupo_t      burst_grp;
   logic [1:0]  burst_step;

   grupo_t      grp_sel, grp_now;
   logic [1:0]  step_now;
   logic        write_now;
   logic [7:0]  grp_base, wr_addr, wr_data, rd_addr;
   logic [23:0] grp_snap;

   logic          tmr_load, tmr_en, tmr_zero;
   logic [TW-1:0] tmr_val;
   logic          fin_trans;

   always_comb begin
      grp_sel = G_HORA;
      if (pend[0])      grp_sel = G_HORA;
      else if (pend[1]) grp_sel = G_FECHA;
      else if (pend[2]) grp_sel = G_CRONO;

      write_now = burst_act || (pend != 3'b000);
      grp_now   = burst_act ? burst_grp : grp_sel;
      step_now  = burst_act ? burst_step : 2'd0;

      grp_base = A_CRONO;
      grp_snap = snap_crono;
      case (grp_now)
         G_HORA: begin
            grp_base = A_SEG;
            grp_snap = snap_hora;
         end
         G_FECHA: begin
            grp_base = A_SEG + OFF_FECHA;
            grp_snap = snap_fecha;
         end
         default: begin
            grp_base = A_CRONO;
            grp_snap = snap_crono;
         end
      endcase

      wr_addr = grp_base + {6'd0, step_now};
      wr_data = byte_sel(grp_snap, step_now);
      rd_addr = (rd_idx < N_SEG_REGS) ? (A_SEG + {4'd0, rd_idx})
                                      : (A_CRONO + {4'd0, rd_idx - N_SEG_REGS});
   end

   // A transaction ends on done or on timeout; done wins if both coincide.
   assign fin_trans = (estado == S_WAIT) && (bus.done || tmr_zero);
   assign tmr_load  = (estado == S_ISSUE) || fin_trans;
   assign tmr_val   = (estado == S_ISSUE) ? LD_WAIT : LD_GAP;
   assign tmr_en    = (estado == S_WAIT) || (estado == S_GAP);

   rtc_temporizador #(.W(TW)) u_temporizador (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .en       (tmr_en),
      .zero     (tmr_zero)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         estado               <= S_IDLE;
         bus.inicio           <= 1'b0;
         bus.busy             <= 1'b0;
         bus.address          <= 8'h00;
         bus.DATA_WRITE       <= 8'h00;
         bus.IndicadorMaquina <= 1'b0;
         barrido_fin          <= 1'b0;
         error                <= 1'b0;
         rd_idx               <= 4'd0;
         pend                 <= 3'b000;
         snap_hora            <= 24'h0;
         snap_fecha           <= 24'h0;
         snap_crono           <= 24'h0;
         burst_act            <= 1'b0;
         burst_grp            <= G_HORA;
         burst_step           <= 2'd0;
      end else begin
         barrido_fin <= 1'b0;

         case (estado)
            S_IDLE: begin
               estado     <= S_ISSUE;
               bus.inicio <= 1'b1;
               bus.busy   <= 1'b1;
               if (write_now) begin
                  bus.address          <= wr_addr;
                  bus.DATA_WRITE       <= wr_data;
                  bus.IndicadorMaquina <= 1'b1;
                  burst_act            <= 1'b1;
                  burst_grp            <= grp_now;
                  burst_step           <= step_now;
               end else begin
                  bus.address          <= rd_addr;
                  bus.DATA_WRITE       <= 8'h00;
                  bus.IndicadorMaquina <= 1'b0;
               end
            end

            S_ISSUE: begin
               estado     <= S_WAIT;
               bus.inicio <= 1'b0;
            end

            S_WAIT: begin
               if (fin_trans) begin
                  estado   <= S_GAP;
                  bus.busy <= 1'b0;
                  if (!bus.done) error <= 1'b1;
                  if (bus.IndicadorMaquina) begin
                     if (burst_step == ULT_PASO) begin
                        burst_act  <= 1'b0;
                        burst_step <= 2'd0;
                        case (burst_grp)
                           G_HORA:  pend[0] <= 1'b0;
                           G_FECHA: pend[1] <= 1'b0;
                           default: pend[2] <= 1'b0;
                        endcase
                     end else begin
                        burst_step <= burst_step + 2'd1;
                     end
                  end else if (rd_idx == ULT_IDX) begin
                     rd_idx      <= 4'd0;
                     barrido_fin <= 1'b1;
                  end else begin
                     rd_idx <= rd_idx + 4'd1;
                  end
               end
            end

            default: begin
               if (tmr_zero) estado <= S_IDLE;
            end
         endcase

         // Commits come last so a new pulse wins over a same-edge burst clear.
         if (camb_hora) begin
            pend[0]   <= 1'b1;
            snap_hora <= wr_hora;
         end
         if (camb_fecha) begin
            pend[1]    <= 1'b1;
            snap_fecha <= wr_fecha;
         end
         if (camb_crono) begin
            pend[2]    <= 1'b1;
            snap_crono <= wr_crono;
         end
      end
   end

endmodule

// File: tb/tb_rtc_secuenciador.sv
// Self-checking bench for rtc_secuenciador: expected transactions are queued as
// stimulus is applied and compared when the DUT raises inicio.
module tb_rtc_secuenciador;

   localparam int GAP     = 16;
   localparam int TMO     = 512;
   localparam int SPACING = 1 + 3 + GAP;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
      logic       wr;
   } tx_t;

   typedef struct {
      logic [7:0]  trig;
      logic [2:0]  camb;   // {crono, fecha, hora}
      logic [23:0] h;
      logic [23:0] f;
      logic [23:0] c;
      int          exp_bf;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        camb_hora = 1'b0, camb_fecha = 1'b0, camb_crono = 1'b0;
   logic [23:0] wr_hora = '0, wr_fecha = '0, wr_crono = '0;
   logic        barrido_fin, error;
   logic        resp_en = 1'b1;
   logic        d1 = 1'b0, d2 = 1'b0;

   rtc_secuenciador_if bus_if ();

   rtc_secuenciador #(.GAP_CYC(GAP), .TIMEOUT(TMO)) dut (
      .clk         (clk),
      .reset       (reset),
      .camb_hora   (camb_hora),
      .camb_fecha  (camb_fecha),
      .camb_crono  (camb_crono),
      .wr_hora     (wr_hora),
      .wr_fecha    (wr_fecha),
      .wr_crono    (wr_crono),
      .bus         (bus_if.master),
      .barrido_fin (barrido_fin),
      .error       (error)
   );

   always #5 clk = ~clk;

   // Responder: done is seen by the DUT on the third edge after inicio rises.
   always @(posedge clk) begin
      d1 <= bus_if.inicio;
      d2 <= d1;
   end
   assign bus_if.done = d2 & resp_en;

   int  cyc = 0;
   int  n_chk = 0, n_fail = 0;
   int  bf_cnt = 0;
   int  last_cyc = 0;
   bit  have_last = 0, chk_sp = 0;
   tx_t exp_q[$];
   tx_t e;
   vec_t vt[4];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   function automatic tx_t mk(input logic [7:0] a, input logic [7:0] d, input logic w);
      tx_t t;
      t.addr = a;
      t.data = d;
      t.wr   = w;
      return t;
   endfunction

   function automatic logic [7:0] rd_a(input int i);
      if (i < 6) return 8'(8'h21 + i);
      return 8'(8'h41 + i - 6);
   endfunction

   function automatic int idx_of(input logic [7:0] a);
      for (int i = 0; i < 9; i++) if (rd_a(i) == a) return i;
      return 0;
   endfunction

   task automatic push_burst(input int g, input logic [23:0] d);
      logic [7:0] base;
      base = (g == 0) ? 8'h21 : (g == 1) ? 8'h24 : 8'h41;
      for (int k = 0; k < 3; k++) exp_q.push_back(mk(8'(base + k), d[8*k +: 8], 1'b1));
   endtask

   always @(negedge clk) begin
      if (barrido_fin) bf_cnt++;
      if (bus_if.inicio) begin
         if (chk_sp && have_last) chk("inicio_spacing", cyc - last_cyc, SPACING);
         last_cyc  = cyc;
         have_last = 1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("tx{addr,data,wr}", {bus_if.address, bus_if.DATA_WRITE, bus_if.IndicadorMaquina}, e);
            chk("busy_at_inicio", bus_if.busy, 1'b1);
         end
      end
   end

   task automatic wait_issue(input logic [7:0] a, input logic w, input int budget, output int c0);
      bit found;
      found = 0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (bus_if.inicio && bus_if.address == a && bus_if.IndicadorMaquina == w) begin
            found = 1;
            break;
         end
      end
      c0 = cyc;
      chk("wait_issue_found", found, 1'b1);
   endtask

   task automatic drain(input int budget);
      for (int k = 0; k < budget && exp_q.size() > 0; k++) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_inicio"}, bus_if.inicio, 1'b0);
      chk({tag, "_address"}, bus_if.address, 8'h00);
      chk({tag, "_data"}, bus_if.DATA_WRITE, 8'h00);
      chk({tag, "_ind"}, bus_if.IndicadorMaquina, 1'b0);
      chk({tag, "_busy"}, bus_if.busy, 1'b0);
      chk({tag, "_barrido_fin"}, barrido_fin, 1'b0);
      chk({tag, "_error"}, error, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, c1, b0, ti;

      vt[0] = '{trig: 8'h23, camb: 3'b001, h: 24'h123456, f: 24'h0,      c: 24'h0,      exp_bf: 0};
      vt[1] = '{trig: 8'h42, camb: 3'b110, h: 24'h0,      f: 24'h240315, c: 24'h010203, exp_bf: 1};
      vt[2] = '{trig: 8'h26, camb: 3'b111, h: 24'h095930, f: 24'h991231, c: 24'h000001, exp_bf: 0};
      vt[3] = '{trig: 8'h43, camb: 3'b001, h: 24'h235958, f: 24'h0,      c: 24'h0,      exp_bf: 1};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");

      // Plain sweep: 21..26, 41..43, wrap to 21
      bf_cnt = 0;
      for (int i = 0; i < 9; i++) exp_q.push_back(mk(rd_a(i), 8'h00, 1'b0));
      exp_q.push_back(mk(8'h21, 8'h00, 1'b0));
      have_last = 0;
      chk_sp    = 1;
      reset     = 1'b1;
      drain(400);
      chk_sp = 0;
      chk("barrido_fin_count", bf_cnt, 1);

      // Table: commits during a read, bursts by priority, sweep resumes
      for (int v = 0; v < 4; v++) begin
         wait_issue(vt[v].trig, 1'b0, 1000, c0);
         b0 = bf_cnt;
         @(posedge clk); #1;
         wr_hora    = vt[v].h;
         wr_fecha   = vt[v].f;
         wr_crono   = vt[v].c;
         camb_hora  = vt[v].camb[0];
         camb_fecha = vt[v].camb[1];
         camb_crono = vt[v].camb[2];
         if (vt[v].camb[0]) push_burst(0, vt[v].h);
         if (vt[v].camb[1]) push_burst(1, vt[v].f);
         if (vt[v].camb[2]) push_burst(2, vt[v].c);
         ti = idx_of(vt[v].trig);
         exp_q.push_back(mk(rd_a((ti + 1) % 9), 8'h00, 1'b0));
         exp_q.push_back(mk(rd_a((ti + 2) % 9), 8'h00, 1'b0));
         @(posedge clk); #1;
         camb_hora = 1'b0; camb_fecha = 1'b0; camb_crono = 1'b0;
         drain(800);
         chk("vec_barrido_fin", bf_cnt - b0, vt[v].exp_bf);
      end

      // Crono re-commit between 1st and 2nd write
      wait_issue(8'h24, 1'b0, 1000, c0);
      @(posedge clk); #1;
      wr_crono = 24'h112233; camb_crono = 1'b1;
      exp_q.push_back(mk(8'h41, 8'h33, 1'b1));
      @(posedge clk); #1;
      camb_crono = 1'b0;
      wait_issue(8'h41, 1'b1, 400, c0);
      @(posedge clk); #1;
      wr_crono = 24'h445566; camb_crono = 1'b1;
      exp_q.push_back(mk(8'h42, 8'h55, 1'b1));
      exp_q.push_back(mk(8'h43, 8'h44, 1'b1));
      exp_q.push_back(mk(8'h25, 8'h00, 1'b0));
      exp_q.push_back(mk(8'h26, 8'h00, 1'b0));
      @(posedge clk); #1;
      camb_crono = 1'b0;
      drain(400);

      // Timeout: no done for read 25
      wait_issue(8'h25, 1'b0, 1000, c0);
      chk("error_before_timeout", error, 1'b0);
      @(posedge clk); #1;
      resp_en = 1'b0;
      exp_q.push_back(mk(8'h26, 8'h00, 1'b0));
      for (int k = 0; k < TMO + 50; k++) begin
         @(negedge clk);
         if (error) break;
      end
      c1 = cyc;
      chk("error_set", error, 1'b1);
      chk("timeout_latency", c1 - c0, TMO + 1);
      chk("busy_after_abort", bus_if.busy, 1'b0);
      resp_en = 1'b1;
      drain(100);
      chk("error_sticky", error, 1'b1);

      // Reset during the WAIT of a write burst
      wait_issue(8'h42, 1'b0, 1000, c0);
      @(posedge clk); #1;
      wr_hora = 24'h235959; camb_hora = 1'b1;
      exp_q.push_back(mk(8'h21, 8'h59, 1'b1));
      @(posedge clk); #1;
      camb_hora = 1'b0;
      wait_issue(8'h21, 1'b1, 400, c0);
      resp_en = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk_all_zero("midburst_reset");
      exp_q.push_back(mk(8'h21, 8'h00, 1'b0));
      exp_q.push_back(mk(8'h22, 8'h00, 1'b0));
      resp_en = 1'b1;
      reset   = 1'b1;
      drain(200);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
